reg_write_arbiter: RTL and testbench

- Shares the write port of a bank of bounded read/write configuration registers between two requesters.
- Requester A is the host/management bus; requester B is the internal power sequencer.
- Arbitrates between them round-robin, drives a one-cycle write into the addressed register, and checks that register's bounds alarm.
- Returns ACK or ERR to the winning requester and counts rejected writes for status readback.

---
 rtl/reg_arb_pkg.sv | 24 ++
 rtl/reg_arb_sat_counter.sv | 43 ++++
 rtl/reg_write_arbiter.sv | 153 +++++++++++++++
 tb/tb_reg_write_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_arb_pkg.sv
// Shared types and constants for the register write arbiter.
// Optional feature macro used by the top: REG_ARB_HOST_LOCK_EN.
package reg_arb_pkg;

    // Arbiter FSM states; the encoding is visible on the DBG_STATE port.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WRITE     = 3'd1,
        ST_CHECK     = 3'd2,
        ST_RANGE_ERR = 3'd3,
        ST_RESP      = 3'd4
    } arb_state_e;

    // Requester that owns the current (or most recent) transaction.
    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_e;

    // All-ones saturation value for the error counter.
    // Counters narrower than 32 bits take the low bits.
    localparam logic [31:0] ERR_CNT_SAT = 32'hFFFF_FFFF;

endpackage

// File: rtl/reg_arb_sat_counter.sv
// Saturating event counter with synchronous clear.
// Clear and increment in the same cycle load 1, so the event is not lost.
module reg_arb_sat_counter
    import reg_arb_pkg::*;
#(
    parameter int P_W = 8
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           clr_i,
    input  logic           inc_i,
    output logic [P_W-1:0] cnt_o
);

    localparam logic [P_W-1:0] SAT = ERR_CNT_SAT[P_W-1:0];

    logic [P_W-1:0] cnt_q;
    logic [P_W-1:0] cnt_d;

    // Next count: clear has priority, but a same-cycle event still counts once.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i && inc_i) begin
            cnt_d = P_W'(1);
        end else if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != SAT)) begin
            cnt_d = cnt_q + P_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one register-bank write port between the host
// bus (A) and the power sequencer (B). Each grant issues a single write strobe,
// checks the register's bounds alarm the following cycle, and answers the
// winner with a one-cycle ACK or ERR.
// Optional feature: define REG_ARB_HOST_LOCK_EN to add LOCK_A, which
// restricts grants to requester A while it is high.
//
// Handshake: a requester raises REQ_x with stable ADDR_x/DATA_x and holds it
// until it sees ACK_x or ERR_x; address and data are captured at grant, and
// the response is always delivered once granted, even if REQ_x drops early.
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int P_NUM_REGS = 8,
    parameter int P_ADDR_W   = 3,
    parameter int P_WIDTH    = 16,
    parameter int P_CNT_W    = 8
) (
    input  logic                  CLOCK,
    input  logic                  RESET_N,
    input  logic                  REQ_A,
    input  logic [P_ADDR_W-1:0]   ADDR_A,
    input  logic [P_WIDTH-1:0]    DATA_A,
    output logic                  ACK_A,
    output logic                  ERR_A,
    input  logic                  REQ_B,
    input  logic [P_ADDR_W-1:0]   ADDR_B,
    input  logic [P_WIDTH-1:0]    DATA_B,
    output logic                  ACK_B,
    output logic                  ERR_B,
    output logic [P_NUM_REGS-1:0] REG_SELECT,
    output logic                  REG_WRITE,
    output logic [P_WIDTH-1:0]    REG_DATA,
    input  logic [P_NUM_REGS-1:0] REG_ALARM,
    input  logic                  CLR_ERR,
    output logic [P_CNT_W-1:0]    ERR_COUNT,
    output logic                  BUSY,
`ifdef REG_ARB_HOST_LOCK_EN
    input  logic                  LOCK_A,
`endif
    output logic [2:0]            DBG_STATE
);

    localparam int IDX_W = (P_NUM_REGS > 1) ? $clog2(P_NUM_REGS) : 1;
    localparam logic [P_NUM_REGS-1:0] SEL_ONE = P_NUM_REGS'(1);

    arb_state_e           state_q, state_d;
    grant_e               last_grant_q, last_grant_d;
    logic [IDX_W-1:0]     addr_q, addr_d;
    logic [P_WIDTH-1:0]   data_q, data_d;
    logic                 err_flag_q, err_flag_d;

    logic                 req_b_eff;
    logic                 req_any;
    logic                 grant_b;
    logic [P_ADDR_W-1:0]  grant_addr;
    logic [P_WIDTH-1:0]   grant_data;
    logic                 grant_oob;

    // While the host holds the lock, B is invisible to arbitration.
`ifdef REG_ARB_HOST_LOCK_EN
    assign req_b_eff = REQ_B & ~LOCK_A;
`else
    assign req_b_eff = REQ_B;
`endif

    // Round-robin pick: B wins alone, or on contention when A had the last grant.
    assign req_any    = REQ_A | req_b_eff;
    assign grant_b    = req_b_eff & (~REQ_A | (last_grant_q == GRANT_A));
    assign grant_addr = grant_b ? ADDR_B : ADDR_A;
    assign grant_data = grant_b ? DATA_B : DATA_A;
    assign grant_oob  = 32'(grant_addr) >= 32'(P_NUM_REGS);

    // FSM next state and transaction capture.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        data_d       = data_q;
        err_flag_d   = err_flag_q;
        case (state_q)
            ST_IDLE: begin
                if (req_any) begin
                    last_grant_d = grant_b ? GRANT_B : GRANT_A;
                    addr_d       = grant_addr[IDX_W-1:0];
                    err_flag_d   = 1'b0;
                    if (grant_oob) begin
                        state_d = ST_RANGE_ERR;
                    end else begin
                        data_d  = grant_data;
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                err_flag_d = REG_ALARM[addr_q];
                state_d    = ST_RESP;
            end
            ST_RANGE_ERR: begin
                err_flag_d = 1'b1;
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset drops any in-flight transaction.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GRANT_B;
            addr_q       <= '0;
            data_q       <= '0;
            err_flag_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            err_flag_q   <= err_flag_d;
        end
    end

    // Outputs decoded from registered state.
    assign REG_WRITE  = (state_q == ST_WRITE);
    assign REG_SELECT = REG_WRITE ? (SEL_ONE << addr_q) : '0;
    assign REG_DATA   = data_q;
    assign BUSY       = (state_q != ST_IDLE);
    assign ACK_A      = (state_q == ST_RESP) && (last_grant_q == GRANT_A) && !err_flag_q;
    assign ERR_A      = (state_q == ST_RESP) && (last_grant_q == GRANT_A) &&  err_flag_q;
    assign ACK_B      = (state_q == ST_RESP) && (last_grant_q == GRANT_B) && !err_flag_q;
    assign ERR_B      = (state_q == ST_RESP) && (last_grant_q == GRANT_B) &&  err_flag_q;
    assign DBG_STATE  = state_q;

    reg_arb_sat_counter #(
        .P_W (P_CNT_W)
    ) u_err_cnt (
        .clk_i  (CLOCK),
        .rst_ni (RESET_N),
        .clr_i  (CLR_ERR),
        .inc_i  (ERR_A | ERR_B),
        .cnt_o  (ERR_COUNT)
    );

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter (P_ADDR_W=4 so that out-of-range
// addresses can be requested). Includes a small bounded-register bank model
// that raises the alarm when written data exceeds that register's upper bound.
module tb_reg_write_arbiter;

    localparam int NR = 8;
    localparam int AW = 4;
    localparam int DW = 16;
    localparam int CW = 8;

    logic          CLOCK = 1'b0;
    logic          RESET_N = 1'b0;
    logic          REQ_A = 1'b0;
    logic [AW-1:0] ADDR_A = '0;
    logic [DW-1:0] DATA_A = '0;
    logic          ACK_A, ERR_A;
    logic          REQ_B = 1'b0;
    logic [AW-1:0] ADDR_B = '0;
    logic [DW-1:0] DATA_B = '0;
    logic          ACK_B, ERR_B;
    logic [NR-1:0] REG_SELECT;
    logic          REG_WRITE;
    logic [DW-1:0] REG_DATA;
    logic [NR-1:0] REG_ALARM;
    logic          CLR_ERR = 1'b0;
    logic [CW-1:0] ERR_COUNT;
    logic          BUSY;
    logic [2:0]    DBG_STATE;
`ifdef REG_ARB_HOST_LOCK_EN
    logic          LOCK_A = 1'b0;
`endif

    always #5 CLOCK = ~CLOCK;

    reg_write_arbiter #(
        .P_NUM_REGS (NR),
        .P_ADDR_W   (AW),
        .P_WIDTH    (DW),
        .P_CNT_W    (CW)
    ) dut (
        .CLOCK      (CLOCK),
        .RESET_N    (RESET_N),
        .REQ_A      (REQ_A),
        .ADDR_A     (ADDR_A),
        .DATA_A     (DATA_A),
        .ACK_A      (ACK_A),
        .ERR_A      (ERR_A),
        .REQ_B      (REQ_B),
        .ADDR_B     (ADDR_B),
        .DATA_B     (DATA_B),
        .ACK_B      (ACK_B),
        .ERR_B      (ERR_B),
        .REG_SELECT (REG_SELECT),
        .REG_WRITE  (REG_WRITE),
        .REG_DATA   (REG_DATA),
        .REG_ALARM  (REG_ALARM),
        .CLR_ERR    (CLR_ERR),
        .ERR_COUNT  (ERR_COUNT),
        .BUSY       (BUSY),
`ifdef REG_ARB_HOST_LOCK_EN
        .LOCK_A     (LOCK_A),
`endif
        .DBG_STATE  (DBG_STATE)
    );

    // Bank model: alarm[i] registered on a write, high when data > upper bound.
    logic [DW-1:0] bank_hi [NR];
    logic [NR-1:0] bank_alarm;
    always @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            bank_alarm <= '0;
        end else if (REG_WRITE) begin
            for (int i = 0; i < NR; i++) begin
                if (REG_SELECT[i]) bank_alarm[i] <= (REG_DATA > bank_hi[i]);
            end
        end
    end
    assign REG_ALARM = bank_alarm;

    int n_checks = 0;
    int n_fail   = 0;
    int model_cnt = 0;
    logic [DW-1:0] last_wdata = '0;

    typedef struct {
        logic          use_b;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          exp_err;
        int            exp_lat;
    } vec_t;
    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        REQ_A = 1'b0;
        REQ_B = 1'b0;
        CLR_ERR = 1'b0;
`ifdef REG_ARB_HOST_LOCK_EN
        LOCK_A = 1'b0;
`endif
        model_cnt = 0;
        last_wdata = '0;
        repeat (2) @(negedge CLOCK);
        RESET_N = 1'b1;
        @(negedge CLOCK);
    endtask

    // Called at a negedge; waits (bounded) for the next response pulse.
    // Optionally scrambles the winner's address/data after it has been granted.
    task automatic do_txn(input string name, input logic exp_b, input logic exp_err,
                          input logic [AW-1:0] exp_addr, input logic [DW-1:0] exp_data,
                          input int exp_lat, input logic scramble);
        int lat, wcnt, busy_low, exp_idle;
        logic [3:0] pul, exp_p;
        logic [NR-1:0] wsel, exp_sel;
        logic [DW-1:0] wdata;
        logic oob;
        lat = 0; wcnt = 0; busy_low = 0; pul = '0; wsel = '0; wdata = '0;
        oob = (32'(exp_addr) >= NR);
        for (int k = 1; k <= 6; k++) begin
            @(negedge CLOCK);
            if (scramble && k == 1) begin
                if (exp_b) begin
                    ADDR_B = AW'($urandom_range(0, 15));
                    DATA_B = DW'($urandom);
                end else begin
                    ADDR_A = AW'($urandom_range(0, 15));
                    DATA_A = DW'($urandom);
                end
            end
            if (!BUSY) busy_low++;
            if (REG_WRITE) begin
                wcnt++;
                wsel = REG_SELECT;
                wdata = REG_DATA;
            end
            if ({ACK_A, ERR_A, ACK_B, ERR_B} != 4'b0000) begin
                lat = k;
                pul = {ACK_A, ERR_A, ACK_B, ERR_B};
                break;
            end
        end
        exp_p = exp_b ? (exp_err ? 4'b0001 : 4'b0010) : (exp_err ? 4'b0100 : 4'b1000);
        exp_idle = exp_lat - (oob ? 2 : 3);
        check({name, ".latency"}, 32'(lat), 32'(exp_lat));
        check({name, ".pulse"}, 32'(pul), 32'(exp_p));
        check({name, ".busy_gaps"}, 32'(busy_low), 32'(exp_idle));
        check({name, ".write_count"}, 32'(wcnt), oob ? 32'd0 : 32'd1);
        if (!oob) begin
            exp_sel = '0;
            exp_sel[exp_addr[2:0]] = 1'b1;
            check({name, ".select"}, 32'(wsel), 32'(exp_sel));
            check({name, ".wdata"}, 32'(wdata), 32'(exp_data));
            last_wdata = exp_data;
        end
        if (exp_err) model_cnt = (model_cnt == 255) ? 255 : model_cnt + 1;
    endtask

    // From the response negedge: drop finished requests, step into IDLE, check.
    task automatic idle_step(input string name, input logic drop_a, input logic drop_b);
        if (drop_a) REQ_A = 1'b0;
        if (drop_b) REQ_B = 1'b0;
        @(negedge CLOCK);
        check({name, ".idle_busy"}, 32'(BUSY), 32'd0);
        check({name, ".err_count"}, 32'(ERR_COUNT), 32'(model_cnt));
        check({name, ".reg_data_hold"}, 32'(REG_DATA), 32'(last_wdata));
    endtask

    initial begin
        int pulses;
        logic pend_a, pend_b, last_b, win_b, exp_err;
        logic [AW-1:0] pa_addr, pb_addr, w_addr;
        logic [DW-1:0] pa_data, pb_data, w_data;

        for (int i = 0; i < NR; i++) bank_hi[i] = 16'h00FF;

        // Reset values.
        RESET_N = 1'b0;
        repeat (2) @(negedge CLOCK);
        check("reset.outputs", {ACK_A, ERR_A, ACK_B, ERR_B, REG_WRITE, BUSY, 26'd0}, 32'd0);
        check("reset.select", 32'(REG_SELECT), 32'd0);
        check("reset.data", 32'(REG_DATA), 32'd0);
        check("reset.count", 32'(ERR_COUNT), 32'd0);
        do_reset();

        // Single-requester vectors (bank bound 0x00FF everywhere).
        vecs[0] = '{1'b0, 4'd2,  16'h0040, 1'b0, 3};
        vecs[1] = '{1'b1, 4'd5,  16'h0100, 1'b1, 3};
        vecs[2] = '{1'b0, 4'd9,  16'h1111, 1'b1, 2};
        vecs[3] = '{1'b1, 4'd0,  16'h00FF, 1'b0, 3};
        vecs[4] = '{1'b0, 4'd7,  16'hFFFF, 1'b1, 3};
        vecs[5] = '{1'b1, 4'd15, 16'h0001, 1'b1, 2};
        vecs[6] = '{1'b0, 4'd8,  16'h0002, 1'b1, 2};
        vecs[7] = '{1'b1, 4'd7,  16'h0000, 1'b0, 3};
        for (int v = 0; v < 8; v++) begin
            if (vecs[v].use_b) begin
                REQ_B = 1'b1; ADDR_B = vecs[v].addr; DATA_B = vecs[v].data;
            end else begin
                REQ_A = 1'b1; ADDR_A = vecs[v].addr; DATA_A = vecs[v].data;
            end
            do_txn($sformatf("vec%0d", v), vecs[v].use_b, vecs[v].exp_err,
                   vecs[v].addr, vecs[v].data, vecs[v].exp_lat, 1'b1);
            idle_step($sformatf("vec%0d", v), ~vecs[v].use_b, vecs[v].use_b);
        end

        // Contention held across three transactions: A, B, A, 4 cycles apart.
        do_reset();
        REQ_A = 1'b1; ADDR_A = 4'd1; DATA_A = 16'h0011;
        REQ_B = 1'b1; ADDR_B = 4'd3; DATA_B = 16'h0033;
        do_txn("rr0", 1'b0, 1'b0, 4'd1, 16'h0011, 3, 1'b0);
        do_txn("rr1", 1'b1, 1'b0, 4'd3, 16'h0033, 4, 1'b0);
        do_txn("rr2", 1'b0, 1'b0, 4'd1, 16'h0011, 4, 1'b0);
        idle_step("rr", 1'b1, 1'b1);

        // Saturation, then clear coinciding with an error pulse, then clear alone.
        do_reset();
        REQ_A = 1'b1; ADDR_A = 4'd9; DATA_A = 16'h0000;
        do_txn("sat_first", 1'b0, 1'b1, 4'd9, 16'h0000, 2, 1'b0);
        for (int i = 0; i < 255; i++) do_txn("sat_fill", 1'b0, 1'b1, 4'd9, 16'h0000, 3, 1'b0);
        do_txn("sat_over", 1'b0, 1'b1, 4'd9, 16'h0000, 3, 1'b0);
        check("sat.count_held", 32'(ERR_COUNT), 32'd255);
        CLR_ERR = 1'b1;
        @(negedge CLOCK);
        CLR_ERR = 1'b0;
        REQ_A = 1'b0;
        check("clr_with_err.count", 32'(ERR_COUNT), 32'd1);
        CLR_ERR = 1'b1;
        @(negedge CLOCK);
        CLR_ERR = 1'b0;
        check("clr_alone.count", 32'(ERR_COUNT), 32'd0);
        model_cnt = 0;

        // Reset asserted during the WRITE cycle.
        do_reset();
        REQ_A = 1'b1; ADDR_A = 4'd4; DATA_A = 16'h1234;
        @(negedge CLOCK);
        check("rst_mid.write_seen", 32'(REG_WRITE), 32'd1);
        RESET_N = 1'b0;
        REQ_A = 1'b0;
        #1;
        check("rst_mid.write", 32'(REG_WRITE), 32'd0);
        check("rst_mid.select", 32'(REG_SELECT), 32'd0);
        check("rst_mid.busy", 32'(BUSY), 32'd0);
        check("rst_mid.data", 32'(REG_DATA), 32'd0);
        @(negedge CLOCK);
        RESET_N = 1'b1;
        pulses = 0;
        repeat (6) begin
            @(negedge CLOCK);
            if (ACK_A || ERR_A || ACK_B || ERR_B) pulses++;
        end
        check("rst_mid.no_response", 32'(pulses), 32'd0);

`ifdef REG_ARB_HOST_LOCK_EN
        // Host lock: B starves while locked, then wins once the lock drops.
        do_reset();
        LOCK_A = 1'b1;
        REQ_A = 1'b1; ADDR_A = 4'd1; DATA_A = 16'h0006;
        REQ_B = 1'b1; ADDR_B = 4'd0; DATA_B = 16'h0005;
        do_txn("lock0", 1'b0, 1'b0, 4'd1, 16'h0006, 3, 1'b0);
        do_txn("lock1", 1'b0, 1'b0, 4'd1, 16'h0006, 4, 1'b0);
        REQ_A = 1'b0;
        pulses = 0;
        repeat (8) begin
            @(negedge CLOCK);
            if (ACK_A || ERR_A || ACK_B || ERR_B || BUSY) pulses++;
        end
        check("lock.b_waits", 32'(pulses), 32'd0);
        LOCK_A = 1'b0;
        do_txn("unlock_b", 1'b1, 1'b0, 4'd0, 16'h0005, 3, 1'b0);
        idle_step("unlock_b", 1'b0, 1'b1);
`endif

        // Randomized traffic against the transaction-level model.
        do_reset();
        for (int i = 0; i < NR; i++) bank_hi[i] = DW'($urandom);
        pend_a = 1'b0; pend_b = 1'b0; last_b = 1'b1;
        pa_addr = '0; pb_addr = '0; pa_data = '0; pb_data = '0;
        for (int it = 0; it < 80; it++) begin
            if (!pend_a && ($urandom_range(0, 1) == 1)) begin
                pend_a = 1'b1; pa_addr = AW'($urandom_range(0, 9)); pa_data = DW'($urandom);
                REQ_A = 1'b1; ADDR_A = pa_addr; DATA_A = pa_data;
            end
            if (!pend_b && ($urandom_range(0, 1) == 1)) begin
                pend_b = 1'b1; pb_addr = AW'($urandom_range(0, 9)); pb_data = DW'($urandom);
                REQ_B = 1'b1; ADDR_B = pb_addr; DATA_B = pb_data;
            end
            if (!pend_a && !pend_b) begin
                pend_a = 1'b1; pa_addr = AW'($urandom_range(0, 9)); pa_data = DW'($urandom);
                REQ_A = 1'b1; ADDR_A = pa_addr; DATA_A = pa_data;
            end
            win_b = (pend_a && pend_b) ? !last_b : pend_b;
            w_addr = win_b ? pb_addr : pa_addr;
            w_data = win_b ? pb_data : pa_data;
            exp_err = (32'(w_addr) >= NR) ? 1'b1 : (w_data > bank_hi[w_addr[2:0]]);
            do_txn($sformatf("rnd%0d", it), win_b, exp_err, w_addr, w_data,
                   (32'(w_addr) >= NR) ? 2 : 3, 1'b1);
            last_b = win_b;
            if (win_b) pend_b = 1'b0; else pend_a = 1'b0;
            idle_step($sformatf("rnd%0d", it), !win_b, win_b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
